// File: rtl/wb_pkg.sv
// Shared writeback types: format enum, buffered entry and load formatter.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_OFFW = $clog2(WB_XLEN / 8);

    typedef enum logic [2:0] {
        WB_PASS,
        WB_LB,
        WB_LBU,
        WB_LH,
        WB_LHU,
        WB_LW,
        WB_LWU,
        WB_LD
    } wb_fmt_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
        wb_fmt_e            fmt;
        logic [WB_OFFW-1:0] offset;
    } wb_entry_t;

    typedef struct packed {
        logic [WB_XLEN-1:0] data;
        logic               misaligned;
    } wb_res_t;

    function automatic wb_res_t wb_format(input wb_entry_t e);
        wb_res_t     r;
        logic [7:0]  b8;
        logic [15:0] h16;
        logic [31:0] w32;
        b8  = 8'(e.data >> {e.offset, 3'b000});
        h16 = 16'(e.data >> {e.offset, 3'b000});
        w32 = 32'(e.data >> {e.offset, 3'b000});
        r.data       = e.data;
        r.misaligned = 1'b0;
        case (e.fmt)
            WB_LB:  r.data = WB_XLEN'($signed(b8));
            WB_LBU: r.data = WB_XLEN'(b8);
            WB_LH, WB_LHU: begin
                if (e.offset[0]) begin
                    r.misaligned = 1'b1;
                end else if (e.fmt == WB_LH) begin
                    r.data = WB_XLEN'($signed(h16));
                end else begin
                    r.data = WB_XLEN'(h16);
                end
            end
            // On RV32 a word load is already the full register.
            WB_LW, WB_LWU: begin
                if (WB_XLEN == 64) begin
                    if (e.offset[1:0] != 2'b00) begin
                        r.misaligned = 1'b1;
                    end else if (e.fmt == WB_LW) begin
                        r.data = WB_XLEN'($signed(w32));
                    end else begin
                        r.data = WB_XLEN'(w32);
                    end
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; an extra pointer bit separates full from empty.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge: per-producer FIFOs, round-robin grant, load formatting
// and a single registered regfile write port.
module wb_merge_unit
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int XLEN    = WB_XLEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                src_valid,
    output logic [NUM_SRC-1:0]                src_ready,
    input  logic [NUM_SRC-1:0][4:0]           src_rd,
    input  logic [NUM_SRC-1:0][XLEN-1:0]      src_data,
    input  logic [NUM_SRC-1:0][2:0]           src_fmt,
    input  logic [NUM_SRC-1:0][WB_OFFW-1:0]   src_offset,
    output logic [XLEN-1:0]                   regfile_in,
    output logic [4:0]                        dest,
    output logic                              load_regfile,
    output logic                              misalign_err,
    output logic [NUM_SRC-1:0]                pending
);

    localparam int RRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int EW  = $bits(wb_entry_t);

    logic [NUM_SRC-1:0]      full;
    logic [NUM_SRC-1:0]      empty;
    logic [NUM_SRC-1:0]      push;
    logic [NUM_SRC-1:0]      pop;
    wb_entry_t [NUM_SRC-1:0] head;

    logic [RRW-1:0]  rr_q, rr_d;
    logic            gnt_valid;
    logic [RRW-1:0]  gnt_idx;
    wb_entry_t       sel;
    wb_res_t         res;
    logic            rd_nz;

    logic            load_q;
    logic            mis_q;
    logic [4:0]      dest_q;
    logic [XLEN-1:0] data_q;

    assign src_ready = ~full;
    assign push      = src_valid & ~full;
    assign pending   = ~empty;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
        wb_entry_t in_e;
        assign in_e = '{rd: src_rd[i], data: src_data[i],
                        fmt: wb_fmt_e'(src_fmt[i]),
                        offset: src_offset[i]};
        wb_fifo #(
            .DEPTH(DEPTH),
            .WIDTH(EW)
        ) u_fifo (
            .clk_i  (clk),
            .rst_ni (rst),
            .push_i (push[i]),
            .pop_i  (pop[i]),
            .din_i  (in_e),
            .full_o (full[i]),
            .empty_o(empty[i]),
            .head_o (head[i])
        );
    end

    // First non-empty channel at or after rr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = (int'(rr_q) + k) % NUM_SRC;
            if (!gnt_valid && !empty[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = RRW'(j);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_valid) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    assign sel   = head[gnt_idx];
    assign res   = wb_format(sel);
    assign rd_nz = (sel.rd != 5'd0);

    always_comb begin
        rr_d = rr_q;
        if (gnt_valid) begin
            rr_d = (gnt_idx == RRW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q   <= '0;
            load_q <= 1'b0;
            mis_q  <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            rr_q   <= rr_d;
            load_q <= gnt_valid && rd_nz;
            mis_q  <= gnt_valid && res.misaligned;
            if (gnt_valid) begin
                dest_q <= sel.rd;
                data_q <= rd_nz ? res.data : '0;
            end
        end
    end

`ifndef SYNTHESIS
    always_comb begin
        if (gnt_valid && WB_XLEN == 32 &&
            (sel.fmt == WB_LWU || sel.fmt == WB_LD)) begin
            $error("wb_merge_unit: fmt %0d not legal on RV32", sel.fmt);
        end
    end
`endif

    assign load_regfile = load_q;
    assign misalign_err = mis_q;
    assign dest         = dest_q;
    assign regfile_in   = data_q;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Randomised bench for wb_merge_unit against a queue-based reference.
module tb_wb_merge_unit;

    localparam int N = 3;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N-1:0][4:0] src_rd;
    logic [N-1:0][31:0] src_data;
    logic [N-1:0][2:0] src_fmt;
    logic [N-1:0][1:0] src_offset;
    logic [31:0]      regfile_in;
    logic [4:0]       dest;
    logic             load_regfile;
    logic             misalign_err;
    logic [N-1:0]      pending;

    always #5 clk = ~clk;

    wb_merge_unit dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_rd      (src_rd),
        .src_data    (src_data),
        .src_fmt     (src_fmt),
        .src_offset  (src_offset),
        .regfile_in  (regfile_in),
        .dest        (dest),
        .load_regfile(load_regfile),
        .misalign_err(misalign_err),
        .pending     (pending)
    );

    typedef struct {
        int unsigned rd;
        logic [31:0] data;
        int unsigned fmt;
        int unsigned off;
    } ent_t;

    ent_t        q[N][$];
    int          rr;
    logic        exp_load;
    logic        exp_mis;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    bit          acc[N];
    bit          hold[N];
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void fmt_ref(input ent_t e, output logic [31:0] v,
                                    output bit mis);
        logic [31:0] w;
        w   = e.data >> (8 * e.off);
        v   = e.data;
        mis = 1'b0;
        case (e.fmt)
            1: begin
                v = w & 32'hFF;
                if (v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2: v = w & 32'hFF;
            3, 4: begin
                if (e.off % 2 == 1) begin
                    mis = 1'b1;
                end else begin
                    v = w & 32'hFFFF;
                    if (e.fmt == 3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rr       = 0;
        exp_load = 1'b0;
        exp_mis  = 1'b0;
        exp_dest = '0;
        exp_data = '0;
    endtask

    task automatic cycle();
        int          g;
        ent_t        e;
        logic [31:0] v;
        bit          mis;
        for (int i = 0; i < N; i++) begin
            check($sformatf("src_ready[%0d]", i), src_ready[i],
                  q[i].size() < D);
            check($sformatf("pending[%0d]", i), pending[i],
                  q[i].size() != 0);
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && q[(rr + k) % N].size() != 0) g = (rr + k) % N;
        end
        for (int i = 0; i < N; i++) acc[i] = src_valid[i] && q[i].size() < D;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            e = q[g].pop_front();
            rr = (g + 1) % N;
            fmt_ref(e, v, mis);
            exp_load = (e.rd != 0);
            exp_dest = 5'(e.rd);
            exp_data = (e.rd != 0) ? v : 32'h0;
            exp_mis  = mis;
        end else begin
            exp_load = 1'b0;
            exp_mis  = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                q[i].push_back('{src_rd[i], src_data[i], src_fmt[i],
                                 src_offset[i]});
            end
        end
        check("load_regfile", load_regfile, exp_load);
        check("dest", dest, exp_dest);
        check("regfile_in", regfile_in, exp_data);
        check("misalign_err", misalign_err, exp_mis);
    endtask

    task automatic drive(input int ch, input int rd, input logic [31:0] data,
                         input int fmt, input int off);
        src_valid[ch]  = 1'b1;
        src_rd[ch]     = 5'(rd);
        src_data[ch]   = data;
        src_fmt[ch]    = 3'(fmt);
        src_offset[ch] = 2'(off);
    endtask

    task automatic idle(input int n);
        src_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic new_entry(input int ch);
        drive(ch, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
              $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
        src_valid[ch] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        src_valid  = '0;
        src_rd     = '0;
        src_data   = '0;
        src_fmt    = '0;
        src_offset = '0;
        model_reset();
        #1;
        check("rst_load", load_regfile, 1'b0);
        check("rst_dest", dest, 5'd0);
        check("rst_data", regfile_in, 32'h0);
        check("rst_mis", misalign_err, 1'b0);
        check("rst_ready", src_ready, 3'b111);
        check("rst_pending", pending, 3'b000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        cycle();

        drive(0, 5, 32'h80FF_1234, 1, 3);
        cycle();
        idle(1);
        check("lb_load", load_regfile, 1'b1);
        check("lb_dest", dest, 5'd5);
        check("lb_data", regfile_in, 32'hFFFF_FF80);
        check("lb_mis", misalign_err, 1'b0);

        drive(0, 7, 32'hBEEF_CAFE, 4, 2);
        cycle();
        idle(1);
        check("lhu_data", regfile_in, 32'h0000_BEEF);
        drive(0, 7, 32'hBEEF_CAFE, 4, 1);
        cycle();
        idle(1);
        check("lhu_mis_data", regfile_in, 32'hBEEF_CAFE);
        check("lhu_mis_err", misalign_err, 1'b1);
        check("lhu_mis_load", load_regfile, 1'b1);
        idle(1);
        check("lhu_mis_pulse", misalign_err, 1'b0);

        drive(2, 0, 32'hDEAD_BEEF, 0, 0);
        cycle();
        idle(1);
        check("rd0_load", load_regfile, 1'b0);
        idle(1);
        check("rd0_pending", pending, 3'b000);

        drive(0, 1, 32'h11, 0, 0);
        drive(1, 2, 32'h22, 0, 0);
        drive(2, 3, 32'h33, 0, 0);
        cycle();
        idle(1);
        check("burst1_a", dest, 5'd1);
        idle(1);
        check("burst1_b", dest, 5'd2);
        idle(1);
        check("burst1_c", dest, 5'd3);
        drive(0, 4, 32'h44, 0, 0);
        drive(1, 5, 32'h55, 0, 0);
        drive(2, 6, 32'h66, 0, 0);
        cycle();
        idle(1);
        check("burst2_a", dest, 5'd4);
        idle(1);
        check("burst2_b", dest, 5'd5);
        idle(1);
        check("burst2_c", dest, 5'd6);

        for (int i = 0; i < N; i++) drive(i, 8 + i, 32'h100 + i, 0, 0);
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (c == 1) check("ch1_full", src_ready[1], 1'b0);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) drive(i, 8 + 3 * (c + 1) + i, $urandom, 0, 0);
            end
        end
        idle(8);

        for (int i = 0; i < N; i++) drive(i, 20 + i, $urandom, 0, 0);
        cycle();
        cycle();
        idle(1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_load", load_regfile, 1'b0);
        check("mid_rst_dest", dest, 5'd0);
        check("mid_rst_data", regfile_in, 32'h0);
        check("mid_rst_pending", pending, 3'b000);
        check("mid_rst_ready", src_ready, 3'b111);
        model_reset();
        #3 rst = 1'b1;
        idle(4);

        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) new_entry(i);
            end
            cycle();
            for (int i = 0; i < N; i++) hold[i] = src_valid[i] && !acc[i];
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
- Writeback merge stage for the pipelined RV32 core with multi-cycle units (load path, mul/div, and future units).
- Accepts completed results from NUM_SRC independent producers, each through a valid/ready handshake into its own small FIFO.
- Arbitrates round-robin onto the single regfile write port.
- Performs load byte/half alignment and sign/zero extension on the granted entry, generalised to XLEN and to byte-offset addressing.

Parameters:
- NUM_SRC, 3, number of producer channels (1..8)
- DEPTH, 2, entries per channel FIFO (power of 2, >=2)
- XLEN, 32, data width (32 or 64)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- src_valid  in  NUM_SRC  per-channel result valid
- src_ready  out  NUM_SRC  per-channel space available
- src_rd  in  NUM_SRC x 5  destination register
- src_data  in  NUM_SRC x XLEN  raw result or raw memory word
- src_fmt  in  NUM_SRC x 3  wb_fmt_e: PASS, LB, LBU, LH, LHU, LW, (XLEN=64: LWU, LD)
- src_offset  in  NUM_SRC x log2(XLEN/8)  byte offset of load within word
- regfile_in  out  XLEN  write data
- dest  out  5  write register
- load_regfile  out  1  write enable
- misalign_err  out  1  one-cycle pulse, granted entry misaligned
- pending  out  NUM_SRC  channel FIFO non-empty

Behaviour:
- Reset (rst=0, async): all FIFOs emptied; rr pointer = 0; regfile_in=0, dest=0, load_regfile=0, misalign_err=0. src_ready reads 1 on all channels while reset is asserted and after release.
- Reset mid-operation discards all buffered results; no write occurs for them.
- Push: on edge with src_valid[i] && src_ready[i], entry {rd, data, fmt, offset} enters FIFO i.
- src_ready[i] = !full[i], registered-state based only. There is no pass-through: a push to a full FIFO is refused even if that FIFO pops in the same cycle.
- Arbitration (combinational on FIFO heads): grant the first non-empty channel starting at rr and wrapping modulo NUM_SRC. On grant to channel g, rr <= (g+1) mod NUM_SRC at the edge. rr is unchanged when no channel is non-empty.
- Pop: the granted head is popped on the same edge its formatted result is registered into the output register.
- Simultaneous push and pop on the same FIFO is allowed when it is not full; count is unchanged.
- Output register (1 stage): load_regfile <= grant_valid && (rd != 0); dest <= rd; regfile_in <= formatted data, or 0 when rd == 0.
- With no grant: load_regfile <= 0; dest and regfile_in hold their previous values.
- Latency: push at edge t -> load_regfile high for cycle t+1..t+2 window. Minimum push-edge to write-cycle is 2 edges, i.e. result visible after the second rising edge. Throughput is 1 write/cycle aggregate.
- Formatting, with b = offset:
  - PASS/LW(32)/LD: data unchanged.
  - LB/LBU: byte b, sign-/zero-extended to XLEN.
  - LH/LHU: halfword at byte b; legal only for b even.
  - LW/LWU (XLEN=64): word at b; legal only for b in {0,4}.
- Misaligned LH/LHU/LW/LWU: pass raw data unchanged, still write, misalign_err=1 for the same cycle as load_regfile.
- Illegal fmt value: treated as PASS. Simulation-only $error.
- FIFO pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit.
- rd=0 entries are consumed (pop, rr advance) but produce no write.

Decomposition:
- Package wb_pkg holds:
  - wb_fmt_e enum
  - wb_entry_t struct {rd, data, fmt, offset} parametrised via XLEN localparam
  - function wb_format(entry) returning {data, misaligned}
- Sub-module wb_fifo: generic synchronous FIFO, params DEPTH and WIDTH, async active-low reset, push/pop/full/empty/head. Instantiated NUM_SRC times via generate.

Test Plan:
- Single LB, channel 0, rd=5, data=0x80FF_1234, offset=3 -> two edges later load_regfile=1, dest=5, regfile_in=0xFFFF_FF80, misalign_err=0.
- LHU, rd=7, data=0xBEEF_CAFE, offset=2 -> 0x0000_BEEF. Same with offset=1 -> 0xBEEF_CAFE, misalign_err=1 for one cycle.
- All 3 channels push in the same cycle (rd=1,2,3) with rr=0 -> writes to x1, x2, x3 on consecutive cycles. The next simultaneous burst (rd=4,5,6) writes in order x4, x5, x6, confirming rr wrapped to 0.
- Channel 1 held valid with no pops (other channels flooding, DEPTH=2): after 2 accepts src_ready[1]=0, and the third entry is held by the producer until a pop. No entry is lost or duplicated; write order per channel is FIFO.
- PASS with rd=0, data=0xDEAD_BEEF -> load_regfile stays 0, pending clears, rr advances.
- Assert rst=0 asynchronously with 4 entries buffered -> outputs 0 immediately; after release pending=0 and no writes occur.
